// File: rtl/alu_pkg.sv
// Shared ALU definitions: funct codes for the multiply/move-from commands and
// the multiplier control states. The ALU top level and the bench use them too.
package alu_pkg;

  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_MULT  = 6'd24;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StHold = 2'd2
  } mult_state_e;

endpackage

// File: rtl/shift_add_core.sv
// Iterative shift-add datapath: multiplicand, 64-bit product register, 33-bit
// adder and iteration counter. load_i seeds a new multiply, step_i runs one
// iteration, last_o flags that the current step is the final one.
module shift_add_core #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 load_i,
  input  logic                 step_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 last_o,
  output logic [2*WIDTH-1:0]   prod_next_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q;
  logic [WIDTH:0]     sum;

  // One iteration: conditional add into the upper half (carry kept), then shift right.
  always_comb begin
    sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_d = {sum, prod_q[WIDTH-1:1]};
  end

  assign prod_next_o = prod_d;
  assign last_o      = (cnt_q == CntW'(WIDTH - 1));

  // Datapath registers: seed on load, advance on step, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      mcand_q <= a_i;
      prod_q  <= {{WIDTH{1'b0}}, b_i};
      cnt_q   <= '0;
    end else if (step_i) begin
      prod_q  <= prod_d;
      cnt_q   <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/multu_hilo_unit.sv
// Sequential unsigned multiplier with HI/LO result registers and a registered
// MFHI/MFLO read port. Optional macro MULTU_SIGNED_EN adds signed MULT (funct 24).
module multu_hilo_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output,
  output logic             busy,
  output logic             done
);

  mult_state_e state_q, state_d;

  logic               start_cmd, start_neg;
  logic [WIDTH-1:0]   op_a, op_b;
  logic               core_load, core_step, core_last, commit;
  logic [2*WIDTH-1:0] core_prod, result;
  logic [WIDTH-1:0]   hi_q, lo_q, out_q;
  logic               done_q, neg_q;

  // Start decode; signed MULT feeds magnitudes to the core and remembers the sign.
  always_comb begin
    start_cmd = (Signal == FUNCT_MULTU);
    start_neg = 1'b0;
    op_a      = dataA;
    op_b      = dataB;
`ifdef MULTU_SIGNED_EN
    if (Signal == FUNCT_MULT) begin
      start_cmd = 1'b1;
      start_neg = dataA[WIDTH-1] ^ dataB[WIDTH-1];
      op_a      = dataA[WIDTH-1] ? (~dataA + 1'b1) : dataA;
      op_b      = dataB[WIDTH-1] ? (~dataB + 1'b1) : dataB;
    end
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next state; HOLD waits for the start command to drop so it cannot re-trigger.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_cmd) state_d = StBusy;
      StBusy:  if (core_last) state_d = StHold;
      StHold:  if (!start_cmd) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: core handshakes and commit strobe.
  always_comb begin
    core_load = (state_q == StIdle) && start_cmd;
    core_step = (state_q == StBusy);
    commit    = core_step && core_last;
    busy      = (state_q == StBusy);
  end

  shift_add_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (core_load),
    .step_i     (core_step),
    .a_i        (op_a),
    .b_i        (op_b),
    .last_o     (core_last),
    .prod_next_o(core_prod)
  );

  assign result = neg_q ? (~core_prod + 1'b1) : core_prod;

  // HI/LO commit, done pulse and registered read mux; reads see pre-edge HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      done_q <= commit;
      if (core_load) neg_q <= start_neg;
      if (commit) begin
        hi_q <= result[2*WIDTH-1:WIDTH];
        lo_q <= result[WIDTH-1:0];
      end
      if (Signal == FUNCT_MFHI)      out_q <= hi_q;
      else if (Signal == FUNCT_MFLO) out_q <= lo_q;
      else                           out_q <= '0;
    end
  end

  assign Output = out_q;
  assign done   = done_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
// Scoreboard bench for multu_hilo_unit: the driver queues expected MFHI/MFLO
// data, a monitor pops and compares on the cycle after each read command.
module tb_multu_hilo_unit;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] dataA = '0;
  logic [W-1:0] dataB = '0;
  logic [5:0]   Signal = 6'd0;
  logic [W-1:0] Output;
  logic         busy;
  logic         done;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned done_cnt = 0;
  logic [W-1:0] exp_q[$];

  multu_hilo_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .dataA (dataA),
    .dataB (dataB),
    .Signal(Signal),
    .Output(Output),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: a read command sampled at an edge yields Output after that edge.
  initial begin
    logic [5:0] s;
    logic       r;
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      s = Signal;
      r = reset;
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
      if (!r && (s == FUNCT_MFHI || s == FUNCT_MFLO)) begin
        if (exp_q.size() == 0) begin
          check("unexpected read", 64'(Output), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check(s == FUNCT_MFHI ? "MFHI data" : "MFLO data", 64'(Output), 64'(e));
        end
      end
    end
  end

  // Present a command for exactly one rising edge, then return to a no-op.
  task automatic issue(input logic [5:0] sig, input logic [W-1:0] a, input logic [W-1:0] b);
    Signal = sig;
    dataA  = a;
    dataB  = b;
    @(negedge clk);
    Signal = 6'd0;
  endtask

  task automatic mf(input logic [5:0] sig, input logic [W-1:0] exp);
    exp_q.push_back(exp);
    issue(sig, '0, '0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Bounded wait for the multiplier to go idle.
  task automatic wait_idle(input string name);
    int i;
    i = 0;
    while (busy === 1'b1 && i < 40) begin
      @(negedge clk);
      i++;
    end
    if (busy !== 1'b0) check({name, " busy timeout"}, 64'(busy), 64'd0);
    @(negedge clk);
  endtask

  task automatic multu(input logic [W-1:0] a, input logic [W-1:0] b, input string name);
    issue(FUNCT_MULTU, a, b);
    wait_idle(name);
  endtask

  initial begin
    int d0;
    int early;
    int bad;
    ticks(3);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(done), 64'd0);
    check("reset Output", 64'(Output), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // 3 x 5 with exact timing of busy/done.
    d0 = done_cnt;
    issue(FUNCT_MULTU, 32'd3, 32'd5);
    check("busy after start", 64'(busy), 64'd1);
    early = 0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b1) early++;
    end
    check("no early done", 64'(early), 64'd0);
    @(negedge clk);
    check("done at edge 32", 64'(done), 64'd1);
    check("busy drops at commit", 64'(busy), 64'd0);
    @(negedge clk);
    check("done one cycle", 64'(done), 64'd0);
    check("single done pulse", 64'(done_cnt - d0), 64'd1);
    mf(FUNCT_MFHI, 32'd0);
    mf(FUNCT_MFLO, 32'd15);

    // Max operands.
    multu(32'hFFFF_FFFF, 32'hFFFF_FFFF, "max");
    mf(FUNCT_MFHI, 32'hFFFF_FFFE);
    mf(FUNCT_MFLO, 32'd1);

    // Carry into HI, then zero operand.
    multu(32'd65536, 32'd65536, "2^32");
    mf(FUNCT_MFHI, 32'd1);
    mf(FUNCT_MFLO, 32'd0);

    // MFHI on the commit edge returns the old HI, new HI afterwards.
    issue(FUNCT_MULTU, 32'd3, 32'd5);
    ticks(31);
    mf(FUNCT_MFHI, 32'd1);
    check("done at commit read", 64'(done), 64'd1);
    mf(FUNCT_MFHI, 32'd0);
    mf(FUNCT_MFLO, 32'd15);

    multu(32'd0, 32'd123, "zero");
    mf(FUNCT_MFHI, 32'd0);
    mf(FUNCT_MFLO, 32'd0);

    // Reads during BUSY see the previous result; a second MULTU is ignored.
    multu(32'd3, 32'd5, "3x5 again");
    d0 = done_cnt;
    issue(FUNCT_MULTU, 32'd7, 32'd9);
    ticks(4);
    mf(FUNCT_MFLO, 32'd15);
    ticks(4);
    issue(FUNCT_MULTU, 32'd100, 32'd100);
    wait_idle("7x9");
    check("one done for 7x9", 64'(done_cnt - d0), 64'd1);
    mf(FUNCT_MFLO, 32'd63);
    mf(FUNCT_MFHI, 32'd0);

    // Reset mid-BUSY aborts and clears HI/LO.
    d0 = done_cnt;
    issue(FUNCT_MULTU, 32'd7, 32'd9);
    ticks(9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("busy after abort", 64'(busy), 64'd0);
    check("Output after abort", 64'(Output), 64'd0);
    ticks(36);
    check("no done after abort", 64'(done_cnt - d0), 64'd0);
    mf(FUNCT_MFHI, 32'd0);
    mf(FUNCT_MFLO, 32'd0);

`ifdef MULTU_SIGNED_EN
    issue(FUNCT_MULT, 32'hFFFF_FFFE, 32'd3);
    check("MULT busy", 64'(busy), 64'd1);
    wait_idle("mult");
    mf(FUNCT_MFHI, 32'hFFFF_FFFF);
    mf(FUNCT_MFLO, 32'hFFFF_FFFA);
`else
    issue(FUNCT_MULT, 32'hFFFF_FFFE, 32'd3);
    check("MULT no-op Output", 64'(Output), 64'd0);
    bad = 0;
    for (int i = 0; i < 35; i++) begin
      if (busy !== 1'b0) bad++;
      @(negedge clk);
    end
    check("MULT never busy", 64'(bad), 64'd0);
    mf(FUNCT_MFHI, 32'd0);
    mf(FUNCT_MFLO, 32'd0);
`endif

    ticks(2);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "timeout");
  end

endmodule
